bkm_iter_ctrl: RTL and testbench

- Iteration sequencer for the BKM FPU. It sits directly upstream of lut_decoder and supplies its mode, format, n, d_x_n and d_y_n inputs.
- On a start request it latches the operation mode and format, issues a one-cycle operand-load strobe to the datapath, then steps the iteration index n from 0 to N_ITER-1.
- Each cycle it registers the datapath digit-selector outputs so that each (n, d_x_n, d_y_n) triple reaches lut_decoder cycle-aligned.
- It signals completion with a one-cycle done pulse.

---
 rtl/bkm_iter_ctrl.sv | 105 ++++++++++
 tb/tb_bkm_iter_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bkm_iter_ctrl.sv
// bkm_iter_ctrl: BKM iteration sequencer feeding (mode, format, n, d_x_n, d_y_n) to lut_decoder
module bkm_iter_ctrl #(
    parameter int LOG2N  = 6,
    parameter int N_ITER = 64
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             srst,
    input  logic             enable,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    input  logic [1:0]       format,
    input  logic [1:0]       d_x_in,
    input  logic [1:0]       d_y_in,
    output logic             ready,
    output logic             load,
    output logic             step_valid,
    output logic             lut_mode,
    output logic [1:0]       lut_format,
    output logic [LOG2N-1:0] lut_n,
    output logic [1:0]       lut_d_x_n,
    output logic [1:0]       lut_d_y_n,
    output logic             done,
    output logic             err_digit
);
    typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;
    localparam logic [LOG2N-1:0] LAST = LOG2N'(N_ITER - 1);
    state_t state;
    logic [LOG2N-1:0] cnt;
    logic x_bad, y_bad;
    // digit code 10 is illegal; it is forwarded as zero and flagged
    always_comb begin
        x_bad = d_x_in == 2'b10;
        y_bad = d_y_in == 2'b10;
    end
    // sequencer: pulses clear on every edge unless re-asserted; disabled edges only drop the pulses
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            ready      <= 1'b1;
            load       <= 1'b0;
            step_valid <= 1'b0;
            done       <= 1'b0;
            lut_mode   <= 1'b0;
            lut_format <= 2'b00;
            lut_n      <= '0;
            lut_d_x_n  <= 2'b00;
            lut_d_y_n  <= 2'b00;
            err_digit  <= 1'b0;
        end else if (srst) begin
            state      <= IDLE;
            cnt        <= '0;
            ready      <= 1'b1;
            load       <= 1'b0;
            step_valid <= 1'b0;
            done       <= 1'b0;
            lut_mode   <= 1'b0;
            lut_format <= 2'b00;
            lut_n      <= '0;
            lut_d_x_n  <= 2'b00;
            lut_d_y_n  <= 2'b00;
            err_digit  <= 1'b0;
        end else begin
            load       <= 1'b0;
            step_valid <= 1'b0;
            done       <= 1'b0;
            if (enable) begin
                if (state != IDLE && abort) begin
                    state <= IDLE;
                    ready <= 1'b1;
                end else begin
                    case (state)
                        IDLE: if (start && !abort) begin
                            state      <= LOAD;
                            ready      <= 1'b0;
                            load       <= 1'b1;
                            cnt        <= '0;
                            lut_mode   <= mode;
                            lut_format <= format;
                            err_digit  <= 1'b0;
                        end
                        LOAD: state <= ITER;
                        ITER: begin
                            lut_n      <= cnt;
                            lut_d_x_n  <= x_bad ? 2'b00 : d_x_in;
                            lut_d_y_n  <= y_bad ? 2'b00 : d_y_in;
                            err_digit  <= err_digit | x_bad | y_bad;
                            step_valid <= 1'b1;
                            if (cnt == LAST) state <= DONE;
                            else cnt <= cnt + 1'b1;
                        end
                        DONE: begin
                            done  <= 1'b1;
                            ready <= 1'b1;
                            state <= IDLE;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_bkm_iter_ctrl.sv
// tb_bkm_iter_ctrl: self-checking bench for bkm_iter_ctrl against a latency-schedule model
module tb_bkm_iter_ctrl;
    localparam int LOG2N = 6;
    localparam int N = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic arst_n, srst, enable, start, abort, mode;
    logic [1:0] format, d_x_in, d_y_in;
    logic ready, load, step_valid, lut_mode, done, err_digit;
    logic [1:0] lut_format, lut_d_x_n, lut_d_y_n;
    logic [LOG2N-1:0] lut_n;

    bkm_iter_ctrl #(.LOG2N(LOG2N), .N_ITER(N)) dut (
        .clk(clk), .arst_n(arst_n), .srst(srst), .enable(enable), .start(start),
        .abort(abort), .mode(mode), .format(format), .d_x_in(d_x_in), .d_y_in(d_y_in),
        .ready(ready), .load(load), .step_valid(step_valid), .lut_mode(lut_mode),
        .lut_format(lut_format), .lut_n(lut_n), .lut_d_x_n(lut_d_x_n),
        .lut_d_y_n(lut_d_y_n), .done(done), .err_digit(err_digit)
    );

    int total = 0;
    int bad = 0;

    // model: e counts enabled edges since the accepting edge (accept = 0),
    // step k appears after edge k+2, done after edge N+2
    bit m_busy, m_load, m_sv, m_done, m_err, m_mode;
    bit [1:0] m_fmt, m_dx, m_dy;
    bit [5:0] m_n;
    int m_e;
    int steps_seen;
    bit done_seen;

    typedef struct {
        logic [1:0] dx, dy, ex, ey;
        logic err;
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {14'd0, ready, load, step_valid, done, err_digit, lut_mode, lut_format,
                lut_n, lut_d_x_n, lut_d_y_n};
    endfunction

    function automatic logic [31:0] model_vec();
        return {14'd0, !m_busy, m_load, m_sv, m_done, m_err, m_mode, m_fmt, m_n, m_dx, m_dy};
    endfunction

    function automatic bit [1:0] san(input logic [1:0] d);
        return d == 2'b10 ? 2'b00 : d;
    endfunction

    task automatic m_reset();
        m_busy = 0; m_load = 0; m_sv = 0; m_done = 0; m_err = 0; m_mode = 0;
        m_fmt = 0; m_dx = 0; m_dy = 0; m_n = 0; m_e = 0;
    endtask

    task automatic cyc(input bit st, input bit ab, input bit en, input bit sr,
                       input logic [1:0] dx, input logic [1:0] dy);
        start = st; abort = ab; enable = en; srst = sr; d_x_in = dx; d_y_in = dy;
        @(posedge clk);
        #1;
        m_load = 0; m_sv = 0; m_done = 0;
        if (sr) m_reset();
        else if (en) begin
            if (!m_busy) begin
                if (st && !ab) begin
                    m_busy = 1; m_e = 0; m_mode = mode; m_fmt = format; m_err = 0;
                    m_load = 1; steps_seen = 0;
                end
            end else if (ab) m_busy = 0;
            else begin
                m_e++;
                if (m_e >= 2 && m_e <= N + 1) begin
                    m_sv = 1; m_n = 6'(m_e - 2); m_dx = san(dx); m_dy = san(dy);
                    m_err = m_err | (dx == 2'b10) | (dy == 2'b10);
                end else if (m_e == N + 2) begin
                    m_done = 1; m_busy = 0;
                end
            end
        end
        check("cyc", dut_vec(), model_vec());
        if (step_valid) steps_seen++;
        if (done) begin
            done_seen = 1;
            check("steps", steps_seen, N);
        end
    endtask

    task automatic steps(input int k, input logic [1:0] dx, input logic [1:0] dy);
        for (int i = 0; i < k; i++) cyc(0, 0, 1, 0, dx, dy);
    endtask

    task automatic run_to_done(input int budget);
        done_seen = 0;
        for (int i = 0; i < budget && !done_seen; i++)
            cyc(0, 0, 1, 0, 2'($urandom_range(0, 1)), 2'b11);
        check("done_seen", done_seen, 1);
    endtask

    initial begin
        tbl[0] = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
        tbl[1] = '{2'b01, 2'b11, 2'b01, 2'b11, 1'b0};
        tbl[2] = '{2'b11, 2'b01, 2'b11, 2'b01, 1'b0};
        tbl[3] = '{2'b01, 2'b00, 2'b01, 2'b00, 1'b0};
        tbl[4] = '{2'b00, 2'b11, 2'b00, 2'b11, 1'b0};
        tbl[5] = '{2'b10, 2'b01, 2'b00, 2'b01, 1'b1};
        tbl[6] = '{2'b01, 2'b01, 2'b01, 2'b01, 1'b1};
        tbl[7] = '{2'b11, 2'b10, 2'b11, 2'b00, 1'b1};

        arst_n = 0; srst = 0; enable = 1; start = 0; abort = 0; mode = 0; format = 0;
        d_x_in = 0; d_y_in = 0; steps_seen = 0; done_seen = 0;
        m_reset();
        @(posedge clk);
        #1;
        check("reset", dut_vec(), model_vec());
        arst_n = 1;

        // full run: mode=1, format=10, digits 01/11
        mode = 1; format = 2'b10;
        cyc(1, 0, 1, 0, 2'b01, 2'b11);
        check("load_pulse", load, 1);
        done_seen = 0;
        for (int i = 1; i <= N + 1; i++) begin
            cyc(0, 0, 1, 0, 2'b01, 2'b11);
            if (i >= 2) check("n_order", lut_n, i - 2);
        end
        cyc(0, 0, 1, 0, 2'b01, 2'b11);
        check("done_at_66", done, 1);
        check("ready_back", ready, 1);
        steps(3, 2'b00, 2'b00);

        // digit table, illegal codes sanitized and sticky err
        mode = 0; format = 2'b01;
        cyc(1, 0, 1, 0, 2'b00, 2'b00);
        cyc(0, 0, 1, 0, 2'b00, 2'b00);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 1, 0, tbl[i].dx, tbl[i].dy);
            check("tbl_n", lut_n, i);
            check("tbl_dx", lut_d_x_n, tbl[i].ex);
            check("tbl_dy", lut_d_y_n, tbl[i].ey);
            check("tbl_err", err_digit, tbl[i].err);
        end
        run_to_done(N + 5);
        check("err_sticky", err_digit, 1);
        cyc(0, 0, 1, 0, 2'b00, 2'b00);
        cyc(1, 0, 1, 0, 2'b00, 2'b00);
        check("err_cleared", err_digit, 0);

        // stall at n=10 inside the running op
        cyc(0, 0, 1, 0, 2'b01, 2'b01);
        steps(11, 2'b01, 2'b01);
        check("pre_stall_n", lut_n, 10);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 2'b11, 2'b11);
            check("stall_sv", step_valid, 0);
            check("stall_n", lut_n, 10);
        end
        cyc(0, 0, 1, 0, 2'b01, 2'b01);
        check("resume_n", lut_n, 11);
        run_to_done(N + 5);

        // abort at n=20, then a clean full run
        cyc(1, 0, 1, 0, 2'b00, 2'b00);
        cyc(0, 0, 1, 0, 2'b00, 2'b00);
        steps(21, 2'b01, 2'b00);
        check("pre_abort_n", lut_n, 20);
        cyc(0, 1, 1, 0, 2'b01, 2'b00);
        check("abort_ready", ready, 1);
        check("abort_sv", step_valid, 0);
        done_seen = 0;
        steps(N + 5, 2'b00, 2'b00);
        check("abort_no_done", done_seen, 0);
        cyc(1, 0, 1, 0, 2'b00, 2'b00);
        run_to_done(N + 5);

        // start+abort in idle ignored, start while busy ignored
        cyc(1, 1, 1, 0, 2'b00, 2'b00);
        check("start_abort_idle", ready, 1);
        mode = 1; format = 2'b11;
        cyc(1, 0, 1, 0, 2'b00, 2'b00);
        mode = 0; format = 2'b00;
        for (int i = 0; i < 6; i++) cyc(1, 0, 1, 0, 2'b11, 2'b01);
        check("busy_mode_held", {lut_mode, lut_format}, 3'b111);
        run_to_done(N + 5);

        // async reset at n=30, away from any edge
        cyc(1, 0, 1, 0, 2'b00, 2'b00);
        cyc(0, 0, 1, 0, 2'b00, 2'b00);
        steps(31, 2'b01, 2'b11);
        check("pre_arst_n", lut_n, 30);
        #2;
        arst_n = 0;
        #1;
        m_reset();
        check("arst_immediate", dut_vec(), model_vec());
        @(posedge clk);
        #1;
        check("arst_hold", dut_vec(), model_vec());
        arst_n = 1;

        // sync reset at n=40
        cyc(1, 0, 1, 0, 2'b00, 2'b00);
        cyc(0, 0, 1, 0, 2'b00, 2'b00);
        steps(41, 2'b11, 2'b01);
        check("pre_srst_n", lut_n, 40);
        cyc(0, 0, 1, 1, 2'b11, 2'b01);
        check("srst_ready", ready, 1);

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            mode = 1'($urandom);
            format = 2'($urandom);
            cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 199) == 0),
                ($urandom_range(0, 4) != 0), ($urandom_range(0, 499) == 0),
                2'($urandom), 2'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
